// File: rtl/rgb_pwm_top_if.sv
// rgb_pwm_top_if: switch inputs and dual RGB LED outputs of the dimmer
interface rgb_pwm_top_if;
   logic [15:0] sw;
   logic [2:0]  led0;
   logic [2:0]  led1;
   modport master(output sw, input led0, led1);
   modport slave(input sw, output led0, led1);
endinterface

// File: rtl/rgb_pwm_top.sv
// rgb_pwm_top: switch-driven dual RGB PWM dimmer, one shared 5-bit counter
// Define RGB_GAMMA_EN to map switch duties through g(d) = (d*d + 15) / 31.
module rgb_pwm_top #(
   parameter int PRESCALE = 4
) (
   input logic clk,
   input logic rst,
   rgb_pwm_top_if.slave io
);
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [15:0]     sw_s1, sw_s2;
   logic [PW-1:0]   pre;
   logic [4:0]      cnt;
   logic [2:0][4:0] duty, duty_n;
   logic            mode;
   logic [2:0]      on, led0, led1;
   logic            tick, pend;

   function automatic logic [4:0] gam(input logic [4:0] d);
      logic [9:0] sq;
      sq = {5'd0, d} * {5'd0, d} + 10'd15;
      return 5'(sq / 10'd31);
   endfunction

   assign tick = pre == PW'(PRESCALE - 1);
   assign pend = tick && cnt == 5'd31;

   for (genvar i = 0; i < 3; i++) begin : g_ch
`ifdef RGB_GAMMA_EN
      assign duty_n[i] = gam(sw_s2[5*i +: 5]);
`else
      assign duty_n[i] = sw_s2[5*i +: 5];
`endif
      assign on[i] = (duty[i] == 5'd31) || (cnt < duty[i]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sw_s1 <= '0;
         sw_s2 <= '0;
         pre   <= '0;
         cnt   <= '0;
         duty  <= '0;
         mode  <= 1'b0;
         led0  <= '0;
         led1  <= '0;
      end else begin
         sw_s1 <= io.sw;
         sw_s2 <= sw_s1;
         pre   <= tick ? '0 : pre + 1'b1;
         cnt   <= tick ? cnt + 5'd1 : cnt;
         duty  <= pend ? duty_n : duty;
         mode  <= pend ? sw_s2[15] : mode;
         led0  <= on;
         led1  <= mode ? on : ~on;
      end
   end

   assign io.led0 = led0;
   assign io.led1 = led1;
endmodule

// File: tb/tb_rgb_pwm_top.sv
// tb_rgb_pwm_top: directed checks of reset, per-period high times and mode handling
module tb_rgb_pwm_top;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   logic [2:0] s0[128];
   logic [2:0] s1[128];
   int   h0[3];
   int   h1[3];

`ifdef RGB_GAMMA_EN
   localparam int R8 = 8, R16 = 32, R24 = 76;
`else
   localparam int R8 = 32, R16 = 64, R24 = 96;
`endif

   rgb_pwm_top_if io();
   rgb_pwm_top #(.PRESCALE(4)) dut (.clk(clk), .rst(rst), .io(io));

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // records one LED period (edges 128p+1 .. 128p+128), applying nsw at offset at
   task automatic window(input logic [15:0] nsw, input int at);
      for (int c = 0; c < 3; c++) begin
         h0[c] = 0;
         h1[c] = 0;
      end
      for (int i = 0; i < 128; i++) begin
         if (i == at) io.sw = nsw;
         step();
         s0[i] = io.led0;
         s1[i] = io.led1;
         for (int c = 0; c < 3; c++) begin
            h0[c] += int'(s0[i][c]);
            h1[c] += int'(s1[i][c]);
         end
      end
   endtask

   task automatic chk_win(input string tag, input int e0[3], input int e1[3]);
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("%s_led0_%0d", tag, c), h0[c], e0[c]);
         chk($sformatf("%s_led1_%0d", tag, c), h1[c], e1[c]);
      end
   endtask

   initial begin
      io.sw = 16'hFFFF;
      step();
      step();
      chk("rst_led0", io.led0, 3'b000);
      chk("rst_led1", io.led1, 3'b000);
      rst = 1'b0;
      step();
      chk("first_led0", io.led0, 3'b000);
      chk("first_led1", io.led1, 3'b111);
      repeat (127) step();
      chk("pre_end_led0", io.led0, 3'b000);
      window(16'h0000, 0);
      chk_win("ffff", '{128, 128, 128}, '{128, 128, 128});
      window(16'h8010, 0);
      chk_win("zero", '{0, 0, 0}, '{128, 128, 128});
      window(16'h8008, 0);
      chk_win("r16", '{R16, 0, 0}, '{R16, 0, 0});
      chk("r16_start", s0[0][0], 1'b1);
      chk("r16_last_on", s0[R16-1][0], 1'b1);
      chk("r16_first_off", s0[R16][0], 1'b0);
      chk("r16_led1_start", s1[0][0], 1'b1);
      window(16'h8018, 40);
      chk_win("r8", '{R8, 0, 0}, '{R8, 0, 0});
      window(16'h7FFF, 0);
      chk_win("r24", '{R24, 0, 0}, '{R24, 0, 0});
      chk("r24_first_off", s0[R24][0], 1'b0);
      window(16'hFFFF, 0);
      chk_win("full_m0", '{128, 128, 128}, '{0, 0, 0});
      repeat (50) step();
      chk("lit_before_rst", io.led0, 3'b111);
      rst = 1'b1;
      step();
      chk("mid_rst_led0", io.led0, 3'b000);
      chk("mid_rst_led1", io.led1, 3'b000);
      rst = 1'b0;
      step();
      chk("post_rst_led0", io.led0, 3'b000);
      chk("post_rst_led1", io.led1, 3'b111);
      repeat (127) step();
      chk("post_rst_pre_end", io.led0, 3'b000);
      window(16'hFFFF, 0);
      chk_win("relit", '{128, 128, 128}, '{128, 128, 128});
      chk("relit_start", s0[0], 3'b111);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
